alu_md: RTL and testbench

- Parametrised, registered successor to the single-cycle integer ALU for the next core revision.
- Adds the RV32M multiply/divide group, a valid/ready handshake on both sides, and a registered branch-compare flag.
- Sits between decode/operand-fetch and writeback. Accepts one operation at a time.
- Multi-cycle ops stall upstream through in_ready.

---
 rtl/alu_md_pkg.sv | 47 ++++
 rtl/div_iter.sv | 60 ++++++
 rtl/alu_md.sv | 211 +++++++++++++++++++++
 tb/tb_alu_md.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
// Shared types for the registered ALU with the RV32M multiply/divide group.
// Base opcodes 0-13 keep their legacy 4-bit values, zero-extended to 5 bits.
package alu_md_pkg;

    typedef enum logic [4:0] {
        F_ADD      = 5'd0,
        F_SUB      = 5'd1,
        F_SLL      = 5'd2,
        F_SLT      = 5'd3,
        F_SLTU     = 5'd4,
        F_XOR      = 5'd5,
        F_SRL      = 5'd6,
        F_SRA      = 5'd7,
        F_OR       = 5'd8,
        F_AND      = 5'd9,
        F_ADD_JALR = 5'd10,
        F_BEQ      = 5'd11,
        F_BLT      = 5'd12,
        F_BLTU     = 5'd13,
        F_MUL      = 5'd16,
        F_MULH     = 5'd17,
        F_MULHSU   = 5'd18,
        F_MULHU    = 5'd19,
        F_DIV      = 5'd20,
        F_DIVU     = 5'd21,
        F_REM      = 5'd22,
        F_REMU     = 5'd23
    } func_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Opcodes 16-23: the whole M group.
    function automatic logic is_muldiv(input logic [4:0] f);
        return f[4] && !f[3];
    endfunction

    // Opcodes 20-23: DIV, DIVU, REM, REMU.
    function automatic logic is_div(input logic [4:0] f);
        return f[4:2] == 3'b101;
    endfunction

endpackage

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider on unsigned operands, one quotient bit per cycle.
// done marks the cycle whose clock edge retires the last bit; quot/rem then carry the final values.
module div_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quot,
    output logic [XLEN-1:0] rem
);

    localparam int CW = $clog2(XLEN) + 1;

    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] rem_r;
    logic [XLEN-1:0] quo_r;
    logic [XLEN-1:0] dsr_r;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    // quot/rem are the values after this cycle's step; a borrow in trial restores.
    always_comb begin
        shifted = {rem_r, quo_r[XLEN-1]};
        trial   = shifted - {1'b0, dsr_r};
        quot    = {quo_r[XLEN-2:0], ~trial[XLEN]};
        rem     = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    end

    assign busy = (cnt != '0);
    assign done = (cnt == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(XLEN);
        end else if (busy) begin
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem_r <= '0;
            quo_r <= dividend;
            dsr_r <= divisor;
        end else if (busy) begin
            rem_r <= rem;
            quo_r <= quot;
        end
    end

endmodule

// File: rtl/alu_md.sv
// Registered integer ALU with RV32M multiply/divide and valid/ready on both sides.
// One operation in flight; in_ready is high only while idle.
module alu_md
    import alu_md_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHW     = $clog2(XLEN),
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      func,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_out,
    output logic            cmp
);

    state_e state, state_nxt;

    logic [XLEN-1:0]          sum;
    logic [XLEN-1:0]          base_res;
    logic                     base_cmp;
    logic                     mul_a_sgn, mul_b_sgn;
    logic signed [2*XLEN-1:0] mul_a, mul_b;
    logic signed [2*XLEN-1:0] prod_p0, prod_p1, prod_p2, prod_last;
    logic                     vld_p1, vld_p2, mul_last, mul_acc;
    logic                     div_signed, a_neg, b_neg, div_zero, div_ovf, div_special;
    logic [XLEN-1:0]          a_mag, b_mag, spec_res;
    logic [4:0]               func_p1;
    logic                     q_neg_p1, r_neg_p1;
    logic                     div_start, div_busy, div_done;
    logic [XLEN-1:0]          div_quot, div_rem;
    logic                     load, cmp_d;
    logic [XLEN-1:0]          res_d;

    function automatic logic [XLEN-1:0] mul_sel(input logic [4:0] f,
                                                input logic signed [2*XLEN-1:0] p);
        return (f == F_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    function automatic logic [XLEN-1:0] sign_fix(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

    assign sum = A + B;

    always_comb begin
        base_res = '0;
        base_cmp = 1'b0;
        case (func)
            F_ADD:      base_res = sum;
            F_SUB:      base_res = A - B;
            F_SLL:      base_res = A << B[SHW-1:0];
            F_SLT:      base_res = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            F_SLTU:     base_res = {{(XLEN-1){1'b0}}, A < B};
            F_XOR:      base_res = A ^ B;
            F_SRL:      base_res = A >> B[SHW-1:0];
            F_SRA:      base_res = $signed(A) >>> B[SHW-1:0];
            F_OR:       base_res = A | B;
            F_AND:      base_res = A & B;
            F_ADD_JALR: base_res = {sum[XLEN-1:1], 1'b0};
            F_BEQ:      base_cmp = (A == B);
            F_BLT:      base_cmp = $signed(A) < $signed(B);
            F_BLTU:     base_cmp = (A < B);
            default:    ;
        endcase
    end

    // Operands are widened to 2*XLEN so one signed multiply covers all four variants.
    always_comb begin
        mul_a_sgn = (func == F_MULH) || (func == F_MULHSU);
        mul_b_sgn = (func == F_MULH);
        mul_a     = {{XLEN{mul_a_sgn & A[XLEN-1]}}, A};
        mul_b     = {{XLEN{mul_b_sgn & B[XLEN-1]}}, B};
        prod_p0   = mul_a * mul_b;
    end

    always_comb begin
        div_signed  = (func == F_DIV) || (func == F_REM);
        a_neg       = div_signed & A[XLEN-1];
        b_neg       = div_signed & B[XLEN-1];
        a_mag       = sign_fix(a_neg, A);
        b_mag       = sign_fix(b_neg, B);
        div_zero    = (B == '0);
        div_ovf     = div_signed && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
        div_special = div_zero || div_ovf;
        if (div_zero) begin
            spec_res = func[1] ? A : '1;
        end else begin
            spec_res = func[1] ? '0 : A;
        end
    end

    assign mul_acc   = (state == S_IDLE) && in_valid && is_muldiv(func) && !is_div(func);
    assign mul_last  = (MUL_LAT > 2) ? vld_p2 : vld_p1;
    assign prod_last = (MUL_LAT > 2) ? prod_p2 : prod_p1;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        res_d     = '0;
        cmp_d     = 1'b0;
        div_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && !div_busy) begin
                    if (is_div(func)) begin
                        if (div_special) begin
                            load      = 1'b1;
                            res_d     = spec_res;
                            state_nxt = S_DONE;
                        end else begin
                            div_start = 1'b1;
                            state_nxt = S_DIV;
                        end
                    end else if (is_muldiv(func)) begin
                        if (MUL_LAT == 1) begin
                            load      = 1'b1;
                            res_d     = mul_sel(func, prod_p0);
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_MUL;
                        end
                    end else begin
                        load      = 1'b1;
                        res_d     = base_res;
                        cmp_d     = base_cmp;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (mul_last) begin
                    load      = 1'b1;
                    res_d     = mul_sel(func_p1, prod_last);
                    state_nxt = S_DONE;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    load      = 1'b1;
                    res_d     = func_p1[1] ? sign_fix(r_neg_p1, div_rem)
                                           : sign_fix(q_neg_p1, div_quot);
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign in_ready  = (state == S_IDLE) && !div_busy;
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            alu_out <= '0;
            cmp     <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= mul_acc && (MUL_LAT > 1);
            vld_p2 <= vld_p1 && (MUL_LAT > 2);
            if (load) begin
                alu_out <= res_d;
                cmp     <= cmp_d;
            end
        end
    end

    // Stage p1: operands captured on accept; stage p2 only matters for MUL_LAT=3.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            func_p1  <= func;
            q_neg_p1 <= a_neg ^ b_neg;
            r_neg_p1 <= a_neg;
        end
        if (mul_acc) begin
            prod_p1 <= prod_p0;
        end
        if (vld_p1) begin
            prod_p2 <= prod_p1;
        end
    end

    div_iter #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_mag),
        .divisor  (b_mag),
        .busy     (div_busy),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md at XLEN=32, MUL_LAT=2 with hand-computed expectations.
module tb_alu_md;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  func;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_out;
    logic        cmp;

    int n_vec = 0;
    int n_err = 0;

    alu_md #(
        .XLEN    (32),
        .MUL_LAT (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .cmp       (cmp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        func     = f;
        A        = a;
        B        = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Latency counts clock edges from the accepting edge to out_valid.
    task automatic wait_out(output int lat, output int rdy_bad);
        lat     = 1;
        rdy_bad = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (in_ready !== 1'b0) rdy_bad++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_out,
                          input logic exp_cmp, input int exp_lat);
        int lat, rdy_bad;
        issue(f, a, b);
        wait_out(lat, rdy_bad);
        chk({tag, "/out"}, alu_out, exp_out);
        chk({tag, "/cmp"}, {31'b0, cmp}, {31'b0, exp_cmp});
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        if (exp_lat > 1) chk({tag, "/busy_rdy"}, 32'(rdy_bad), 32'd0);
        take();
        @(negedge clk);
        chk({tag, "/idle"}, {30'b0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        int lat, rdy_bad;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        func      = '0;
        A         = '0;
        B         = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst/out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst/alu_out", alu_out, 32'd0);
        chk("rst/cmp", {31'b0, cmp}, 32'd0);
        chk("rst/in_ready", {31'b0, in_ready}, 32'd1);

        run_op("add",     5'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1);
        run_op("sub",     5'd1,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1);
        run_op("sll",     5'd2,  32'h1,        32'h21,       32'h2,        1'b0, 1);
        run_op("sra",     5'd7,  32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1);
        run_op("srl",     5'd6,  32'h80000000, 32'h24,       32'h08000000, 1'b0, 1);
        run_op("slt",     5'd3,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1);
        run_op("jalr",    5'd10, 32'h1001,     32'h2,        32'h1002,     1'b0, 1);
        run_op("blt",     5'd12, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1);
        run_op("bltu",    5'd13, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1);
        run_op("beq",     5'd11, 32'd5,        32'd5,        32'h0,        1'b1, 1);
        run_op("undef14", 5'd14, 32'd5,        32'd3,        32'h0,        1'b0, 1);
        run_op("undef27", 5'd27, 32'd5,        32'd5,        32'h0,        1'b0, 1);

        run_op("mulh",    5'd17, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 2);
        run_op("mulhsu",  5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 2);
        run_op("mulhu",   5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 2);
        run_op("mul",     5'd16, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 2);

        run_op("div",     5'd20, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
        run_op("rem",     5'd22, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
        run_op("rem_nb",  5'd22, 32'd7,        32'hFFFFFFFE, 32'h1,        1'b0, 33);
        run_op("divu",    5'd21, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        run_op("remu",    5'd23, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        run_op("divu0",   5'd21, 32'h1234,     32'd0,        32'hFFFFFFFF, 1'b0, 1);
        run_op("rem0",    5'd22, 32'd9,        32'd0,        32'd9,        1'b0, 1);
        run_op("div_ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        run_op("rem_ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1);

        // Backpressure: hold the DIV result while a new op is already offered.
        issue(5'd20, 32'd100, 32'hFFFFFFF9);
        wait_out(lat, rdy_bad);
        chk("bp/div_out", alu_out, 32'hFFFFFFF2);
        chk("bp/div_lat", 32'(lat), 32'd33);
        in_valid = 1'b1;
        func     = 5'd0;
        A        = 32'd1;
        B        = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp/hold_out", alu_out, 32'hFFFFFFF2);
            chk("bp/hold_ctl", {30'b0, in_ready, out_valid}, 32'b01);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp/no_bypass", {30'b0, in_ready, out_valid}, 32'b10);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp/next_valid", {31'b0, out_valid}, 32'd1);
        chk("bp/next_out", alu_out, 32'd2);
        take();

        // Reset in the middle of a divide drops the operation.
        issue(5'd20, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstdiv/out_valid", {31'b0, out_valid}, 32'd0);
        chk("rstdiv/alu_out", alu_out, 32'd0);
        chk("rstdiv/in_ready", {31'b0, in_ready}, 32'd1);
        run_op("post_rst_add", 5'd0, 32'd2, 32'd3, 32'd5, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
